uart_sys_ctrl: RTL
==================

Name: uart_sys_ctrl

Overview:
- Host-command decoder between the 8N1 UART receiver/transmitter pair and the NES system memory bus.
- Parses byte-stream commands from the host:
  - 0x02 write byte
  - 0x03 read byte
  - 0x06 hold CPU
  - 0x07 release CPU
- Issues single-byte bus transactions while the 6502 is held.
- Returns read data through the UART transmitter. Holding the CPU is what grants the host access to the memory bus.

Parameters:
- CLKS_PER_BIT, 5: UART bit period in clk cycles. Used only to size the inter-byte timeout.
- BYTE_TIMEOUT_BITS, 40: if the gap between command bytes exceeds BYTE_TIMEOUT_BITS*CLKS_PER_BIT cycles, the partial command is aborted.
- BUS_TIMEOUT, 64: cycles to wait for bus_ack before the transaction is abandoned.
- ERR_BYTE, 8'hFF: value returned for a read that is refused or times out.

Ports:
- clk, in, 1: system clock (25 MHz).
- rst, in, 1: asynchronous, active-high reset.
- rx_valid, in, 1: one-cycle strobe; a received byte is present on rx_data.
- rx_data, in, 8: received byte.
- tx_start, out, 1: one-cycle pulse that starts a UART transmit.
- tx_data, out, 8: byte to transmit; held stable from tx_start until tx_done.
- tx_active, in, 1: UART transmitter is busy.
- tx_done, in, 1: one-cycle pulse at the end of the stop bit.
- bus_addr, out, 16: bus address.
- bus_wdata, out, 8: bus write data.
- bus_we, out, 1: write request; held until bus_ack or timeout.
- bus_re, out, 1: read request; held until bus_ack or timeout.
- bus_rdata, in, 8: read data; valid in the cycle bus_ack is high.
- bus_ack, in, 1: one-cycle transaction completion.
- cpu_hold, out, 1: when 1, holds the 6502 in reset/halt and grants the bus to this block.
- sys_addr_out, out, 16: address of the most recent command, for the debug display.

Behaviour:
- Reset values:
  - tx_start=0, tx_data=0
  - bus_we=0, bus_re=0, bus_addr=0, bus_wdata=0
  - sys_addr_out=0
  - cpu_hold=1
  - state=IDLE, all counters cleared
- States: IDLE, ADDR_HI, ADDR_LO, DATA, BUS_WR, BUS_RD, TX_SEND, TX_WAIT.
- IDLE, on rx_valid:
  - 0x02 or 0x03: latch the opcode, go to ADDR_HI.
  - 0x06: cpu_hold<=1, stay in IDLE.
  - 0x07: cpu_hold<=0, stay in IDLE.
  - Any other byte: ignored.
- ADDR_HI, on rx_valid: latch addr[15:8], go to ADDR_LO.
- ADDR_LO, on rx_valid:
  - Latch addr[7:0] and update sys_addr_out.
  - Write opcode: go to DATA.
  - Read opcode, cpu_hold=1: go to BUS_RD.
  - Read opcode, cpu_hold=0: load ERR_BYTE into tx_data, go to TX_SEND.
- DATA, on rx_valid:
  - cpu_hold=1: latch wdata, go to BUS_WR.
  - cpu_hold=0: discard the byte, go to IDLE.
- BUS_WR: assert bus_we with addr/wdata. On bus_ack, or after BUS_TIMEOUT cycles, deassert and go to IDLE. Bus latency is 1..BUS_TIMEOUT cycles.
- BUS_RD: assert bus_re.
  - On bus_ack: tx_data<=bus_rdata, go to TX_SEND.
  - On timeout: tx_data<=ERR_BYTE, go to TX_SEND.
- TX_SEND:
  - If tx_active=0: pulse tx_start for exactly one cycle, go to TX_WAIT.
  - Otherwise wait in TX_SEND.
- TX_WAIT: on tx_done, go to IDLE. rx_valid bytes arriving during BUS_*/TX_* are dropped.
- Inter-byte timeout:
  - In ADDR_HI, ADDR_LO and DATA, a counter is cleared on every rx_valid.
  - On reaching BYTE_TIMEOUT_BITS*CLKS_PER_BIT the parser returns to IDLE with no bus activity.
- Opcode 0x06/0x07 received mid-command is treated as a data/address byte, not as an opcode.
- bus_we and bus_re are never high simultaneously. Each is asserted for at most one transaction per command.
- rst asserted mid-operation immediately clears all outputs to their reset values; an in-flight bus request is dropped.

Optional Feature:
- Macro: SYSCTRL_WRITE_ACK_EN.
- Defined: after BUS_WR completes, the block goes to TX_SEND with tx_data=8'h02 on ack, or ERR_BYTE on timeout. The host receives one byte per write.
- Undefined: writes are silent, BUS_WR returns directly to IDLE, and the existing host scripts are unchanged.

Decomposition:
- Shared package (sys_ctrl_defs):
  - Opcode constants CMD_WRITE=8'h02, CMD_READ=8'h03, CMD_HOLD=8'h06, CMD_RUN=8'h07.
  - State enum sys_ctrl_state_t.
  - ERR_BYTE default.
- One sub-module, sys_ctrl_timeout: a loadable down-counter with clear and expire outputs, instantiated twice (byte gap and bus wait).

Test Plan:
- Reset, then send 02 80 00 A9 with bus_ack two cycles after bus_we → one write pulse to addr 0x8000 with data 0xA9; sys_addr_out=0x8000; no tx_start.
- Send 03 FF FC with bus_rdata=0x34 and ack after three cycles → exactly one tx_start with tx_data=0x34; state returns to IDLE after tx_done.
- Send 07, then 02 00 10 55 → cpu_hold=0 and no bus_we. Then 03 00 10 → tx_data=0xFF. Then 06 → cpu_hold=1.
- Send 02 12, then idle 201 cycles, then 03 00 20 → first command aborted with no write; read to 0x0020 issued normally.
- Send 03 00 00 with bus_ack never asserted → bus_re drops after 64 cycles and 0xFF is transmitted.
- Assert rst during BUS_RD → bus_re=0 and cpu_hold=1 within the same cycle; the next command 03 00 01 completes normally.

Source files
------------

// File: rtl/uart_sys_ctrl_pkg.sv
// Shared definitions for the UART host-command decoder: opcodes, FSM states
// and the default error byte.
package sys_ctrl_defs;

  localparam logic [7:0] CMD_WRITE        = 8'h02;
  localparam logic [7:0] CMD_READ         = 8'h03;
  localparam logic [7:0] CMD_HOLD         = 8'h06;
  localparam logic [7:0] CMD_RUN          = 8'h07;
  localparam logic [7:0] ERR_BYTE_DEFAULT = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_HI,
    ADDR_LO,
    DATA,
    BUS_WR,
    BUS_RD,
    TX_SEND,
    TX_WAIT
  } sys_ctrl_state_t;

  // States in which the inter-byte gap timer is running.
  function automatic logic in_parse(input sys_ctrl_state_t s);
    return (s inside {ADDR_HI, ADDR_LO, DATA});
  endfunction

endpackage

// File: rtl/uart_sys_ctrl_timeout.sv
// Loadable down-counter: load wins over clear, counts while run is high and
// flags expiry during the last counted cycle.
module sys_ctrl_timeout #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clear,
  input  logic             run,
  output logic             expired
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (clear) begin
      count_q <= '0;
    end else if (run && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign expired = run && (count_q == WIDTH'(1));

endmodule

// File: rtl/uart_sys_ctrl.sv
// Host command decoder bridging the UART byte stream to the NES memory bus.
// Build option SYSCTRL_WRITE_ACK_EN: return a status byte to the host after every bus write.
module uart_sys_ctrl
  import sys_ctrl_defs::*;
#(
  parameter int unsigned CLKS_PER_BIT      = 5,
  parameter int unsigned BYTE_TIMEOUT_BITS = 40,
  parameter int unsigned BUS_TIMEOUT       = 64,
  parameter logic [7:0]  ERR_BYTE          = ERR_BYTE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_active,
  input  logic        tx_done,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  output logic        bus_we,
  output logic        bus_re,
  input  logic [7:0]  bus_rdata,
  input  logic        bus_ack,
  output logic        cpu_hold,
  output logic [15:0] sys_addr_out
);

  localparam int unsigned GAP_CYCLES = BYTE_TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned GAP_W      = $clog2(GAP_CYCLES + 1);
  localparam int unsigned BUS_W      = $clog2(BUS_TIMEOUT + 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);
  localparam logic [BUS_W-1:0] BUS_LOAD = BUS_W'(BUS_TIMEOUT);

  sys_ctrl_state_t state_q, state_d;
  logic        is_read_q, is_read_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        cpu_hold_q, cpu_hold_d;
  logic [15:0] sys_addr_q, sys_addr_d;

  logic gap_load, gap_run, gap_expired;
  logic bus_load, bus_run, bus_expired;

  assign gap_run = in_parse(state_q);
  assign bus_run = (state_q inside {BUS_WR, BUS_RD});

  sys_ctrl_timeout #(.WIDTH(GAP_W)) u_gap_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (gap_load),
    .load_val (GAP_LOAD),
    .clear    (!gap_run),
    .run      (gap_run),
    .expired  (gap_expired)
  );

  sys_ctrl_timeout #(.WIDTH(BUS_W)) u_bus_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (bus_load),
    .load_val (BUS_LOAD),
    .clear    (!bus_run),
    .run      (bus_run),
    .expired  (bus_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      is_read_q  <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      tx_data_q  <= '0;
      cpu_hold_q <= 1'b1;
      sys_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      is_read_q  <= is_read_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      tx_data_q  <= tx_data_d;
      cpu_hold_q <= cpu_hold_d;
      sys_addr_q <= sys_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    is_read_d  = is_read_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    tx_data_d  = tx_data_q;
    cpu_hold_d = cpu_hold_q;
    sys_addr_d = sys_addr_q;
    gap_load   = 1'b0;
    bus_load   = 1'b0;

    case (state_q)
      IDLE: begin
        if (rx_valid) begin
          case (rx_data)
            CMD_WRITE: begin
              is_read_d = 1'b0;
              gap_load  = 1'b1;
              state_d   = ADDR_HI;
            end
            CMD_READ: begin
              is_read_d = 1'b1;
              gap_load  = 1'b1;
              state_d   = ADDR_HI;
            end
            CMD_HOLD: cpu_hold_d = 1'b1;
            CMD_RUN:  cpu_hold_d = 1'b0;
            default: ;
          endcase
        end
      end
      // A byte arriving in the expiry cycle still counts as on time.
      ADDR_HI: begin
        if (rx_valid) begin
          addr_d[15:8] = rx_data;
          gap_load     = 1'b1;
          state_d      = ADDR_LO;
        end else if (gap_expired) begin
          state_d = IDLE;
        end
      end
      ADDR_LO: begin
        if (rx_valid) begin
          addr_d[7:0] = rx_data;
          sys_addr_d  = {addr_q[15:8], rx_data};
          if (!is_read_q) begin
            gap_load = 1'b1;
            state_d  = DATA;
          end else if (cpu_hold_q) begin
            bus_load = 1'b1;
            state_d  = BUS_RD;
          end else begin
            tx_data_d = ERR_BYTE;
            state_d   = TX_SEND;
          end
        end else if (gap_expired) begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (rx_valid) begin
          if (cpu_hold_q) begin
            wdata_d  = rx_data;
            bus_load = 1'b1;
            state_d  = BUS_WR;
          end else begin
            state_d = IDLE;
          end
        end else if (gap_expired) begin
          state_d = IDLE;
        end
      end
      // An ack in the final wait cycle takes priority over the timeout.
      BUS_WR: begin
        if (bus_ack || bus_expired) begin
`ifdef SYSCTRL_WRITE_ACK_EN
          tx_data_d = bus_ack ? CMD_WRITE : ERR_BYTE;
          state_d   = TX_SEND;
`else
          state_d = IDLE;
`endif
        end
      end
      BUS_RD: begin
        if (bus_ack) begin
          tx_data_d = bus_rdata;
          state_d   = TX_SEND;
        end else if (bus_expired) begin
          tx_data_d = ERR_BYTE;
          state_d   = TX_SEND;
        end
      end
      TX_SEND: begin
        if (!tx_active) begin
          state_d = TX_WAIT;
        end
      end
      TX_WAIT: begin
        if (tx_done) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  assign tx_start     = (state_q == TX_SEND) && !tx_active;
  assign tx_data      = tx_data_q;
  assign bus_we       = (state_q == BUS_WR);
  assign bus_re       = (state_q == BUS_RD);
  assign bus_addr     = addr_q;
  assign bus_wdata    = wdata_q;
  assign cpu_hold     = cpu_hold_q;
  assign sys_addr_out = sys_addr_q;

endmodule
